// File: rtl/fetch_redirect_ctrl_pkg.sv
// rtl/fetch_redirect_ctrl_pkg.sv - shared widths, FSM states and constants for fetch redirect control
package fetch_redirect_ctrl_pkg;

    localparam int DEF_ADDR_W = 20;
    localparam int DEF_REG_W  = 4;
    localparam int ZERO_REG   = 0;
    localparam int BUB_W      = 3;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        HAZ_STALL = 2'd1,
        SHADOW    = 2'd2
    } state_e;

endpackage

// File: rtl/fetch_redirect_ctrl_if.sv
// rtl/fetch_redirect_ctrl_if.sv - ID/EX status in, fetch control and statistics out
interface fetch_redirect_ctrl_if
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int REG_W  = DEF_REG_W,
    parameter int CNT_W  = 16
);

    logic              id_valid;
    logic              id_is_jump;
    logic [ADDR_W-1:0] id_jump_target;
    logic [REG_W-1:0]  id_rs_a;
    logic [REG_W-1:0]  id_rs_b;
    logic              id_uses_a;
    logic              id_uses_b;
    logic              ex_valid;
    logic              ex_is_load;
    logic [REG_W-1:0]  ex_rd;
    logic              ex_is_branch;
    logic              ex_branch_taken;
    logic [ADDR_W-1:0] ex_branch_target;

    logic              stall;
    logic              jumpEnable;
    logic [ADDR_W-1:0] jumpAddress;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic [CNT_W-1:0]  redirect_count;
    logic [CNT_W-1:0]  stall_count;

    modport master (
        output id_valid, id_is_jump, id_jump_target, id_rs_a, id_rs_b, id_uses_a, id_uses_b,
        output ex_valid, ex_is_load, ex_rd, ex_is_branch, ex_branch_taken, ex_branch_target,
        input  stall, jumpEnable, jumpAddress, flush_if_id, flush_id_ex,
        input  redirect_count, stall_count
    );

    modport slave (
        input  id_valid, id_is_jump, id_jump_target, id_rs_a, id_rs_b, id_uses_a, id_uses_b,
        input  ex_valid, ex_is_load, ex_rd, ex_is_branch, ex_branch_taken, ex_branch_target,
        output stall, jumpEnable, jumpAddress, flush_if_id, flush_id_ex,
        output redirect_count, stall_count
    );

endinterface

// File: rtl/fetch_redirect_ctrl_load_use_detect.sv
// rtl/fetch_redirect_ctrl_load_use_detect.sv - combinational load-use hazard comparator
module load_use_detect
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int REG_W = DEF_REG_W
) (
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [REG_W-1:0] ex_rd,
    input  logic [REG_W-1:0] id_rs_a,
    input  logic [REG_W-1:0] id_rs_b,
    input  logic             id_uses_a,
    input  logic             id_uses_b,
    output logic             hazard
);

    logic load_writes;
    logic match_a;
    logic match_b;

    // The zero register is hardwired, so a load targeting it never produces data to wait for.
    always_comb begin
        load_writes = ex_valid && ex_is_load && (ex_rd != REG_W'(ZERO_REG));
        match_a     = id_uses_a && (id_rs_a == ex_rd);
        match_b     = id_uses_b && (id_rs_b == ex_rd);
        hazard      = load_writes && (match_a || match_b);
    end

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - fetch stall/redirect/flush decision FSM with saturating event counters
module fetch_redirect_ctrl
    import fetch_redirect_ctrl_pkg::*;
#(
    parameter int ADDR_W            = DEF_ADDR_W,
    parameter int REG_W             = DEF_REG_W,
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    fetch_redirect_ctrl_if.slave bus
);

    localparam logic [BUB_W-1:0] LOAD_BUBBLES = BUB_W'(LOAD_STALL_CYCLES - 1);

    state_e            state_q, state_d;
    logic [BUB_W-1:0]  bub_q, bub_d;
    logic [CNT_W-1:0]  redirect_count_q, redirect_count_d;
    logic [CNT_W-1:0]  stall_count_q, stall_count_d;

    logic              br;
    logic              jp;
    logic              lu;
    logic              stall;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_addr;
    logic              flush_if_id;
    logic              flush_id_ex;

    assign br = bus.ex_valid && bus.ex_is_branch && bus.ex_branch_taken;
    assign jp = bus.id_valid && bus.id_is_jump;

    load_use_detect #(.REG_W(REG_W)) u_load_use_detect (
        .ex_valid   (bus.ex_valid),
        .ex_is_load (bus.ex_is_load),
        .ex_rd      (bus.ex_rd),
        .id_rs_a    (bus.id_rs_a),
        .id_rs_b    (bus.id_rs_b),
        .id_uses_a  (bus.id_uses_a),
        .id_uses_b  (bus.id_uses_b),
        .hazard     (lu)
    );

    // Fetch consumes these at the same edge, so every decision is purely combinational.
    always_comb begin
        state_d     = state_q;
        bub_d       = bub_q;
        stall       = 1'b0;
        jump_en     = 1'b0;
        jump_addr   = '0;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if (!reset) begin
            if (br) begin
                jump_en     = 1'b1;
                jump_addr   = bus.ex_branch_target;
                flush_if_id = 1'b1;
                flush_id_ex = 1'b1;
                state_d     = SHADOW;
            end else if (jp && (state_q != SHADOW)) begin
                jump_en     = 1'b1;
                jump_addr   = bus.id_jump_target;
                flush_if_id = 1'b1;
                state_d     = SHADOW;
            end else if (lu && (state_q == RUN)) begin
                stall       = 1'b1;
                flush_id_ex = 1'b1;
                bub_d       = LOAD_BUBBLES;
                state_d     = (LOAD_BUBBLES != '0) ? HAZ_STALL : RUN;
            end else if (state_q == HAZ_STALL) begin
                // bub_q counts the stall cycles still owed, this one included.
                stall       = 1'b1;
                flush_id_ex = 1'b1;
                bub_d       = (bub_q != '0) ? bub_q - BUB_W'(1) : '0;
                state_d     = (bub_d == '0) ? RUN : HAZ_STALL;
            end else begin
                state_d     = RUN;
            end
        end
    end

    always_comb begin
        redirect_count_d = redirect_count_q;
        stall_count_d    = stall_count_q;
        if (jump_en && (redirect_count_q != '1)) begin
            redirect_count_d = redirect_count_q + CNT_W'(1);
        end
        if (stall && (stall_count_q != '1)) begin
            stall_count_d = stall_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q          <= RUN;
            bub_q            <= '0;
            redirect_count_q <= '0;
            stall_count_q    <= '0;
        end else begin
            state_q          <= state_d;
            bub_q            <= bub_d;
            redirect_count_q <= redirect_count_d;
            stall_count_q    <= stall_count_d;
        end
    end

    assign bus.stall          = stall;
    assign bus.jumpEnable     = jump_en;
    assign bus.jumpAddress    = jump_addr;
    assign bus.flush_if_id    = flush_if_id;
    assign bus.flush_id_ex    = flush_id_ex;
    assign bus.redirect_count = redirect_count_q;
    assign bus.stall_count    = stall_count_q;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed vector bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;
    import fetch_redirect_ctrl_pkg::*;

    typedef struct packed {
        logic        id_valid;
        logic        id_is_jump;
        logic [19:0] id_jump_target;
        logic [3:0]  id_rs_a;
        logic [3:0]  id_rs_b;
        logic        id_uses_a;
        logic        id_uses_b;
        logic        ex_valid;
        logic        ex_is_load;
        logic [3:0]  ex_rd;
        logic        ex_is_branch;
        logic        ex_branch_taken;
        logic [19:0] ex_branch_target;
    } in_t;

    typedef struct packed {
        logic        stall;
        logic        jen;
        logic [19:0] jaddr;
        logic        fif;
        logic        fie;
        logic [15:0] rc;
        logic [15:0] sc;
    } exp_t;

    typedef struct packed {
        in_t  in;
        exp_t ex;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    in_t  cur   = '0;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    always #5 clock = ~clock;

    fetch_redirect_ctrl_if #(.ADDR_W(20), .REG_W(4), .CNT_W(16)) bus_a ();
    fetch_redirect_ctrl_if #(.ADDR_W(20), .REG_W(4), .CNT_W(4))  bus_b ();

    assign {bus_a.id_valid, bus_a.id_is_jump, bus_a.id_jump_target, bus_a.id_rs_a, bus_a.id_rs_b,
            bus_a.id_uses_a, bus_a.id_uses_b, bus_a.ex_valid, bus_a.ex_is_load, bus_a.ex_rd,
            bus_a.ex_is_branch, bus_a.ex_branch_taken, bus_a.ex_branch_target} = cur;
    assign {bus_b.id_valid, bus_b.id_is_jump, bus_b.id_jump_target, bus_b.id_rs_a, bus_b.id_rs_b,
            bus_b.id_uses_a, bus_b.id_uses_b, bus_b.ex_valid, bus_b.ex_is_load, bus_b.ex_rd,
            bus_b.ex_is_branch, bus_b.ex_branch_taken, bus_b.ex_branch_target} = cur;

    fetch_redirect_ctrl #(.ADDR_W(20), .REG_W(4), .LOAD_STALL_CYCLES(2), .CNT_W(16)) dut_a (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a)
    );

    fetch_redirect_ctrl #(.ADDR_W(20), .REG_W(4), .LOAD_STALL_CYCLES(3), .CNT_W(4)) dut_b (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b)
    );

    function automatic in_t f_idle();
        in_t v = '0;
        return v;
    endfunction

    function automatic in_t f_jump(input logic [19:0] t);
        in_t v = '0;
        v.id_valid = 1'b1;
        v.id_is_jump = 1'b1;
        v.id_jump_target = t;
        return v;
    endfunction

    function automatic in_t f_lu(input logic [3:0] rd, input logic [3:0] ra, input logic ua,
                                 input logic [3:0] rb, input logic ub);
        in_t v = '0;
        v.ex_valid = 1'b1;
        v.ex_is_load = 1'b1;
        v.ex_rd = rd;
        v.id_rs_a = ra;
        v.id_uses_a = ua;
        v.id_rs_b = rb;
        v.id_uses_b = ub;
        return v;
    endfunction

    function automatic in_t f_br(input logic [19:0] t, input logic taken);
        in_t v = '0;
        v.ex_valid = 1'b1;
        v.ex_is_branch = 1'b1;
        v.ex_branch_taken = taken;
        v.ex_branch_target = t;
        return v;
    endfunction

    function automatic exp_t e(input logic st, input logic jen, input logic [19:0] a,
                               input logic fif, input logic fie, input logic [15:0] rc,
                               input logic [15:0] sc);
        exp_t x;
        x.stall = st;
        x.jen = jen;
        x.jaddr = a;
        x.fif = fif;
        x.fie = fie;
        x.rc = rc;
        x.sc = sc;
        return x;
    endfunction

    task automatic add(input in_t i, input exp_t x);
        vec_t v;
        v.in = i;
        v.ex = x;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    task automatic cyc(input logic rst, input in_t v);
        @(negedge clock);
        reset = rst;
        cur = v;
        #2;
    endtask

    task automatic chk_a(input string tag, input exp_t x);
        chk({tag, " stall"}, 32'(bus_a.stall), 32'(x.stall));
        chk({tag, " jumpEnable"}, 32'(bus_a.jumpEnable), 32'(x.jen));
        chk({tag, " jumpAddress"}, 32'(bus_a.jumpAddress), 32'(x.jaddr));
        chk({tag, " flush_if_id"}, 32'(bus_a.flush_if_id), 32'(x.fif));
        chk({tag, " flush_id_ex"}, 32'(bus_a.flush_id_ex), 32'(x.fie));
        chk({tag, " redirect_count"}, 32'(bus_a.redirect_count), 32'(x.rc));
        chk({tag, " stall_count"}, 32'(bus_a.stall_count), 32'(x.sc));
    endtask

    task automatic chk_b_ctl(input string tag, input logic st, input logic jen,
                             input logic [19:0] a, input logic fif, input logic fie);
        chk({tag, " b stall"}, 32'(bus_b.stall), 32'(st));
        chk({tag, " b jumpEnable"}, 32'(bus_b.jumpEnable), 32'(jen));
        chk({tag, " b jumpAddress"}, 32'(bus_b.jumpAddress), 32'(a));
        chk({tag, " b flush_if_id"}, 32'(bus_b.flush_if_id), 32'(fif));
        chk({tag, " b flush_id_ex"}, 32'(bus_b.flush_id_ex), 32'(fie));
    endtask

    initial begin
        // Single-cycle vectors for dut_a (2 bubbles per load-use, 16-bit counters), chained from RUN.
        add(f_idle(),                                  e(0, 0, 20'h0,     0, 0, 0, 0));
        add(f_jump(20'h00ABC),                         e(0, 1, 20'h00ABC, 1, 0, 0, 0));
        add(f_jump(20'h00ABC),                         e(0, 0, 20'h0,     0, 0, 1, 0));
        add(f_idle(),                                  e(0, 0, 20'h0,     0, 0, 1, 0));
        add(f_lu(4'd3, 4'd3, 1, 4'd0, 0),              e(1, 0, 20'h0,     0, 1, 1, 0));
        add(f_idle(),                                  e(1, 0, 20'h0,     0, 1, 1, 1));
        add(f_idle(),                                  e(0, 0, 20'h0,     0, 0, 1, 2));
        add(f_lu(4'd0, 4'd0, 1, 4'd0, 0),              e(0, 0, 20'h0,     0, 0, 1, 2));
        add(f_lu(4'd5, 4'd0, 0, 4'd5, 1),              e(1, 0, 20'h0,     0, 1, 1, 2));
        add(f_lu(4'd5, 4'd0, 0, 4'd5, 1),              e(1, 0, 20'h0,     0, 1, 1, 3));
        add(f_idle(),                                  e(0, 0, 20'h0,     0, 0, 1, 4));
        add(f_lu(4'd5, 4'd5, 0, 4'd0, 0),              e(0, 0, 20'h0,     0, 0, 1, 4));
        add(f_br(20'h12345, 1) | f_jump(20'h00010) | f_lu(4'd3, 4'd3, 1, 4'd0, 0),
                                                       e(0, 1, 20'h12345, 1, 1, 1, 4));
        add(f_br(20'h00777, 1),                        e(0, 1, 20'h00777, 1, 1, 2, 4));
        add(f_lu(4'd3, 4'd3, 1, 4'd0, 0),              e(0, 0, 20'h0,     0, 0, 3, 4));
        add(f_jump(20'h00020),                         e(0, 1, 20'h00020, 1, 0, 3, 4));
        add(f_idle(),                                  e(0, 0, 20'h0,     0, 0, 4, 4));
        add(f_br(20'h00999, 0),                        e(0, 0, 20'h0,     0, 0, 4, 4));
        add(f_lu(4'd3, 4'd3, 1, 4'd0, 0),              e(1, 0, 20'h0,     0, 1, 4, 4));
        add(f_idle(),                                  e(1, 0, 20'h0,     0, 1, 4, 5));

        // Reset with a taken branch and a load-use hazard both asserted.
        cyc(1'b1, f_br(20'h12345, 1) | f_lu(4'd3, 4'd3, 1, 4'd0, 0));
        chk_a("rst", e(0, 0, 20'h0, 0, 0, 0, 0));
        chk_b_ctl("rst", 0, 0, 20'h0, 0, 0);
        chk("rst b stall_count", 32'(bus_b.stall_count), 32'd0);
        chk("rst a state", 32'(dut_a.state_q), 32'(RUN));

        foreach (tbl[i]) begin
            cyc(1'b0, tbl[i].in);
            chk_a($sformatf("v%0d", i), tbl[i].ex);
        end
        cyc(1'b0, f_idle());
        chk_a("tbl end", e(0, 0, 20'h0, 0, 0, 4, 6));

        // Branch aborts a 3-cycle stall in its second cycle, then reset lands mid-stall.
        cyc(1'b1, f_idle());
        cyc(1'b0, f_lu(4'd3, 4'd3, 1, 4'd0, 0));
        chk_b_ctl("abort c1", 1, 0, 20'h0, 0, 1);
        cyc(1'b0, f_br(20'h00ABC, 1));
        chk_b_ctl("abort c2", 0, 1, 20'h00ABC, 1, 1);
        cyc(1'b0, f_idle());
        chk_b_ctl("abort shadow", 0, 0, 20'h0, 0, 0);
        chk("abort shadow state", 32'(dut_b.state_q), 32'(SHADOW));
        cyc(1'b0, f_lu(4'd3, 4'd3, 1, 4'd0, 0));
        chk_b_ctl("midrst c1", 1, 0, 20'h0, 0, 1);
        cyc(1'b0, f_idle());
        chk_b_ctl("midrst c2", 1, 0, 20'h0, 0, 1);
        chk("midrst c2 state", 32'(dut_b.state_q), 32'(HAZ_STALL));
        cyc(1'b1, f_idle());
        chk_b_ctl("midrst rst", 0, 0, 20'h0, 0, 0);
        chk("midrst b stall_count", 32'(bus_b.stall_count), 32'd3);
        chk("midrst b redirect_count", 32'(bus_b.redirect_count), 32'd1);
        cyc(1'b0, f_idle());
        chk_b_ctl("post rst", 0, 0, 20'h0, 0, 0);
        chk("post rst b state", 32'(dut_b.state_q), 32'(RUN));
        chk("post rst b stall_count", 32'(bus_b.stall_count), 32'd0);
        chk("post rst b redirect_count", 32'(bus_b.redirect_count), 32'd0);

        // Twenty load-use events: dut_b's 4-bit stall counter saturates, dut_a's keeps counting.
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, f_lu(4'd7, 4'd0, 0, 4'd7, 1));
            cyc(1'b0, f_idle());
            cyc(1'b0, f_idle());
            if (k == 9) begin
                chk("sat mid b stall_count", 32'(bus_b.stall_count), 32'd15);
                chk("sat mid a stall_count", 32'(bus_a.stall_count), 32'd20);
            end
        end
        cyc(1'b0, f_idle());
        chk("sat b stall_count", 32'(bus_b.stall_count), 32'd15);
        chk("sat a stall_count", 32'(bus_a.stall_count), 32'd40);
        chk("sat b stall", 32'(bus_b.stall), 32'd0);
        chk("sat b redirect_count", 32'(bus_b.redirect_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
